// File: rtl/clock_phase_monitor.sv
// Quadrature phase checker: samples ph_0/90/180/270 in the clk domain and verifies the
// code rotation, dwell and direction, reporting lock, direction, error pulses and a count.
module clock_phase_monitor #(
   parameter int unsigned QTR        = 1,
   parameter int unsigned LOCK_STEPS = 4,
   parameter int unsigned ERR_W      = 8
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             ph_0,
   input  logic             ph_90,
   input  logic             ph_180,
   input  logic             ph_270,
   output logic             locked,
   output logic             reverse,
   output logic [1:0]       phase_idx,
   output logic             err_pulse,
   output logic [ERR_W-1:0] err_cnt
);

   localparam int unsigned DW = $clog2(QTR + 1);
   localparam int unsigned GW = $clog2(LOCK_STEPS + 1);

   typedef enum logic [1:0] {
      ACQUIRE = 2'd0,
      TRACK   = 2'd1,
      LOCKED  = 2'd2
   } state_e;

   state_e           state_q, state_d;
   logic [3:0]       s_q, s_prev_q;
   logic [DW-1:0]    dwell_q, dwell_d;
   logic [GW-1:0]    good_q, good_d;
   logic             locked_q, locked_d;
   logic             reverse_q, reverse_d;
   logic [1:0]       phase_idx_q, phase_idx_d;
   logic             err_pulse_q, err_pulse_d;
   logic [ERR_W-1:0] err_cnt_q, err_cnt_d;

   logic [3:0] v_c;
   logic       fwd_c, rev_c, step_c, at_qtr_c, both_valid_c, err_c;

   function automatic logic code_valid(input logic [3:0] c);
      return (c == 4'b1001) || (c == 4'b0011) || (c == 4'b0110) || (c == 4'b1100);
   endfunction

   function automatic logic [1:0] code_idx(input logic [3:0] c);
      logic [1:0] idx;
      idx = 2'd0;
      case (c)
         4'b0011: idx = 2'd1;
         4'b0110: idx = 2'd2;
         4'b1100: idx = 2'd3;
         default: idx = 2'd0;
      endcase
      return idx;
   endfunction

   // Step classification of the current sample against the previous one
   always_comb begin
      v_c          = {ph_270, ph_180, ph_90, ph_0};
      fwd_c        = (s_q == {s_prev_q[2:0], s_prev_q[3]});
      rev_c        = (s_q == {s_prev_q[0], s_prev_q[3:1]});
      step_c       = (s_q != s_prev_q);
      at_qtr_c     = (dwell_q == DW'(QTR));
      both_valid_c = code_valid(s_q) && code_valid(s_prev_q);
      err_c        = !code_valid(s_q)
                   || (!step_c && at_qtr_c)
                   || (step_c && !at_qtr_c)
                   || (step_c && (reverse_q ? !rev_c : !fwd_c));
   end

   // Next-state and output decode
   always_comb begin
      state_d     = state_q;
      good_d      = good_q;
      locked_d    = locked_q;
      reverse_d   = reverse_q;
      err_pulse_d = 1'b0;
      err_cnt_d   = err_cnt_q;
      dwell_d     = step_c ? DW'(1) : (at_qtr_c ? dwell_q : dwell_q + DW'(1));

      case (state_q)
         ACQUIRE: begin
            if (both_valid_c && (fwd_c || rev_c)) begin
               reverse_d = rev_c;
               dwell_d   = DW'(1);
               good_d    = '0;
               state_d   = TRACK;
            end
         end
         TRACK, LOCKED: begin
            if (err_c) begin
               err_pulse_d = 1'b1;
               if (err_cnt_q != {ERR_W{1'b1}}) err_cnt_d = err_cnt_q + ERR_W'(1);
               locked_d = 1'b0;
               state_d  = ACQUIRE;
            end else if ((state_q == TRACK) && step_c) begin
               good_d = good_q + GW'(1);
               if (good_d == GW'(LOCK_STEPS)) begin
                  locked_d = 1'b1;
                  state_d  = LOCKED;
               end
            end
         end
         default: state_d = ACQUIRE;
      endcase

      phase_idx_d = (state_d == LOCKED) ? code_idx(s_q) : 2'd0;
   end

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         state_q     <= ACQUIRE;
         s_q         <= '0;
         s_prev_q    <= '0;
         dwell_q     <= '0;
         good_q      <= '0;
         locked_q    <= 1'b0;
         reverse_q   <= 1'b0;
         phase_idx_q <= 2'd0;
         err_pulse_q <= 1'b0;
         err_cnt_q   <= '0;
      end else begin
         state_q     <= state_d;
         s_q         <= v_c;
         s_prev_q    <= s_q;
         dwell_q     <= dwell_d;
         good_q      <= good_d;
         locked_q    <= locked_d;
         reverse_q   <= reverse_d;
         phase_idx_q <= phase_idx_d;
         err_pulse_q <= err_pulse_d;
         err_cnt_q   <= err_cnt_d;
      end
   end

   assign locked    = locked_q;
   assign reverse   = reverse_q;
   assign phase_idx = phase_idx_q;
   assign err_pulse = err_pulse_q;
   assign err_cnt   = err_cnt_q;

endmodule
